hazard_ctrl_mc: RTL

Next-generation hazard controller for the 5-stage pipelined core. It handles EX-stage forwarding, load-use stall, branch flush, a blocking multi-cycle execute unit (MUL/DIV) and data-memory wait states. A 3-state FSM owns pipeline freeze decisions and a watchdog flags a hung multi-cycle op. Sits beside the datapath; drives all stage-register enables and flushes.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_ctrl_mc_if.sv | 53 +++++
 rtl/hazard_fwd.sv | 35 +++
 rtl/hazard_ctrl_mc.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and constants for the hazard controller slice.
//                fwd_sel_t  - forwarding mux select encoding
//                hz_state_t - pipeline freeze FSM state encoding
//                HZ_REG_AW_DEF - default register address width
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

   localparam int HZ_REG_AW_DEF = 5;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MC_WAIT  = 2'd1,
      MEM_WAIT = 2'd2
   } hz_state_t;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_mc_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_mc_if
//  Description : Datapath <-> hazard controller signal bundle.
//                master : datapath side (drives stage info, receives controls)
//                slave  : hazard controller side
//                Inputs to controller : rs1D rs2D rs1E rs2E rdE rdM rdW,
//                  regWriteE/M/W, memReadE, pcSrcE, mcStartE, mcDone,
//                  dmemReqM, dmemReady
//                Outputs of controller: forwardAE/BE, stallF/D/E/M,
//                  flushD/E/M/W, mcErr, perfStallCnt/perfFlushCnt/perfMcCnt
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_mc_if #(
   parameter int REG_AW = hazard_pkg::HZ_REG_AW_DEF,
   parameter int PERF_W = 32
);
   logic [REG_AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic              regWriteE, regWriteM, regWriteW;
   logic              memReadE;
   logic              pcSrcE;
   logic              mcStartE;
   logic              mcDone;
   logic              dmemReqM;
   logic              dmemReady;

   logic [1:0]        forwardAE, forwardBE;
   logic              stallF, stallD, stallE, stallM;
   logic              flushD, flushE, flushM, flushW;
   logic              mcErr;
   logic [PERF_W-1:0] perfStallCnt, perfFlushCnt, perfMcCnt;

   modport master (
      output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
      output regWriteE, regWriteM, regWriteW, memReadE, pcSrcE,
      output mcStartE, mcDone, dmemReqM, dmemReady,
      input  forwardAE, forwardBE,
      input  stallF, stallD, stallE, stallM,
      input  flushD, flushE, flushM, flushW,
      input  mcErr, perfStallCnt, perfFlushCnt, perfMcCnt
   );

   modport slave (
      input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
      input  regWriteE, regWriteM, regWriteW, memReadE, pcSrcE,
      input  mcStartE, mcDone, dmemReqM, dmemReady,
      output forwardAE, forwardBE,
      output stallF, stallD, stallE, stallM,
      output flushD, flushE, flushM, flushW,
      output mcErr, perfStallCnt, perfFlushCnt, perfMcCnt
   );
endinterface : hazard_ctrl_mc_if
`default_nettype wire

// File: rtl/hazard_fwd.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd
//  Description : EX-stage forwarding select for one source operand.
//                The younger producer (M) wins over W; x0 never forwards.
//  Ports       : rsE        - source register of the instruction in E
//                rdM, rdW   - destination registers in M and W
//                regWriteM/W- stage writes its destination
//                fwd        - FWD_M / FWD_W / FWD_RF
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd
   import hazard_pkg::*;
#(
   parameter int REG_AW = HZ_REG_AW_DEF
) (
   input  logic [REG_AW-1:0] rsE,
   input  logic [REG_AW-1:0] rdM,
   input  logic [REG_AW-1:0] rdW,
   input  logic              regWriteM,
   input  logic              regWriteW,
   output fwd_sel_t          fwd
);

   always_comb begin
      fwd = FWD_RF;
      if (regWriteM && (rdM != '0) && (rdM == rsE)) begin
         fwd = FWD_M;
      end else if (regWriteW && (rdW != '0) && (rdW == rsE)) begin
         fwd = FWD_W;
      end
   end

endmodule : hazard_fwd
`default_nettype wire

// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_mc
//  Description : Hazard controller for the 5-stage core: EX forwarding,
//                load-use stall, branch flush, blocking multi-cycle unit and
//                data-memory wait states, with a multi-cycle watchdog.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset
//                hz    - hazard_ctrl_mc_if.slave (stage info in, controls out)
//  Options     : HAZARD_PERF_EN - enables the three performance counters;
//                when undefined the perf outputs are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_mc
   import hazard_pkg::*;
#(
   parameter int REG_AW     = HZ_REG_AW_DEF,
   parameter int MC_MAX_CYC = 64,
   parameter int PERF_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   hazard_ctrl_mc_if.slave  hz
);

   localparam int WD_W = $clog2(MC_MAX_CYC + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(MC_MAX_CYC);

   localparam logic [1:0] ST_RUN      = RUN;
   localparam logic [1:0] ST_MC_WAIT  = MC_WAIT;
   localparam logic [1:0] ST_MEM_WAIT = MEM_WAIT;

   // ------------------------------------------------------------------
   // Forwarding (independent of FSM state)
   // ------------------------------------------------------------------
   fwd_sel_t fwd_a, fwd_b;

   hazard_fwd #(.REG_AW(REG_AW)) u_fwd_a (
      .rsE       (hz.rs1E),
      .rdM       (hz.rdM),
      .rdW       (hz.rdW),
      .regWriteM (hz.regWriteM),
      .regWriteW (hz.regWriteW),
      .fwd       (fwd_a)
   );

   hazard_fwd #(.REG_AW(REG_AW)) u_fwd_b (
      .rsE       (hz.rs2E),
      .rdM       (hz.rdM),
      .rdW       (hz.rdW),
      .regWriteM (hz.regWriteM),
      .regWriteW (hz.regWriteW),
      .fwd       (fwd_b)
   );

   assign hz.forwardAE = fwd_a;
   assign hz.forwardBE = fwd_b;

   // ------------------------------------------------------------------
   // Freeze FSM and watchdog
   // ------------------------------------------------------------------
   logic [1:0]      state_d, state_q;
   logic [WD_W-1:0] wd_d, wd_q;
   logic            mc_err_d, mc_err_q;
   logic            load_use;
   logic            stall_f, stall_d, stall_e, stall_m;
   logic            flush_d, flush_e, flush_m, flush_w;

   // regWriteE is not needed: a load in E always writes its rd.
   assign load_use = hz.memReadE && (hz.rdE != '0) &&
                     ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

   always_comb begin
      state_d  = state_q;
      wd_d     = wd_q;
      mc_err_d = mc_err_q;
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      stall_m  = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      flush_m  = 1'b0;
      flush_w  = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (hz.dmemReqM && !hz.dmemReady) begin
               // Whole pipe freezes; a taken branch in E is re-seen later.
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               stall_m = 1'b1;
               flush_w = 1'b1;
               state_d = ST_MEM_WAIT;
            end else if (hz.mcStartE) begin
               // A result on the start cycle means no wait is needed.
               if (!hz.mcDone) begin
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  stall_e = 1'b1;
                  flush_m = 1'b1;
                  wd_d    = '0;
                  state_d = ST_MC_WAIT;
               end
            end else if (hz.pcSrcE) begin
               // Wrong-path instructions in D and E are squashed; any
               // load-use stall against them is moot.
               flush_d = 1'b1;
               flush_e = 1'b1;
            end else if (load_use) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
            end
         end

         ST_MC_WAIT: begin
            if (hz.mcDone) begin
               state_d = ST_RUN;
            end else begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               flush_m = 1'b1;
               if (wd_q != WD_MAX) begin
                  wd_d = wd_q + 1'b1;
               end
               // Error is flagged but the wait continues until mcDone or reset.
               if (wd_d == WD_MAX) begin
                  mc_err_d = 1'b1;
               end
            end
         end

         ST_MEM_WAIT: begin
            if (hz.dmemReady) begin
               state_d = ST_RUN;
            end else begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               stall_m = 1'b1;
               flush_w = 1'b1;
            end
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         wd_q     <= '0;
         mc_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wd_q     <= wd_d;
         mc_err_q <= mc_err_d;
      end
   end

   assign hz.stallF = stall_f;
   assign hz.stallD = stall_d;
   assign hz.stallE = stall_e;
   assign hz.stallM = stall_m;
   assign hz.flushD = flush_d;
   assign hz.flushE = flush_e;
   assign hz.flushM = flush_m;
   assign hz.flushW = flush_w;
   assign hz.mcErr  = mc_err_q;

   // ------------------------------------------------------------------
   // Performance counters (wrap naturally at 2**PERF_W)
   // ------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
   logic              mc_enter;
   logic [PERF_W-1:0] perf_stall_d, perf_stall_q;
   logic [PERF_W-1:0] perf_flush_d, perf_flush_q;
   logic [PERF_W-1:0] perf_mc_d, perf_mc_q;

   assign mc_enter = (state_q == ST_RUN) && (state_d == ST_MC_WAIT);

   always_comb begin
      perf_stall_d = perf_stall_q + PERF_W'(stall_f);
      perf_flush_d = perf_flush_q + PERF_W'(flush_d);
      perf_mc_d    = perf_mc_q + PERF_W'(mc_enter);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
         perf_mc_q    <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
         perf_mc_q    <= perf_mc_d;
      end
   end

   assign hz.perfStallCnt = perf_stall_q;
   assign hz.perfFlushCnt = perf_flush_q;
   assign hz.perfMcCnt    = perf_mc_q;
`else
   assign hz.perfStallCnt = {PERF_W{1'b0}};
   assign hz.perfFlushCnt = {PERF_W{1'b0}};
   assign hz.perfMcCnt    = {PERF_W{1'b0}};
`endif

endmodule : hazard_ctrl_mc
`default_nettype wire
